// File: rtl/hls_bb_driver.sv
// Initiator for an ap_ctrl_hs black box: takes one request at a time, starts the block,
// captures its result on ap_done (or a watchdog timeout) and returns it on a response port.
module hls_bb_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_cmd,
  input  logic [4:0]       req_x,
  input  logic             req_y,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             ap_continue,
  output logic             ap_ce,
  output logic             bb_cmd,
  output logic [4:0]       bb_x,
  output logic             bb_y,
  input  logic [5:0]       bb_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4:0]       rsp_sum,
  output logic             rsp_err,
  output logic             rsp_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StResp} state_e;

  localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             bb_cmd_q, bb_cmd_d;
  logic [4:0]       bb_x_q, bb_x_d;
  logic             bb_y_q, bb_y_d;
  logic [15:0]      timer_q, timer_d;
  logic [4:0]       rsp_sum_q, rsp_sum_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             ce_q;
  logic             in_flight;
  logic             capture;
  logic             expire;

  // ap_idle is status only; the handshake never depends on it.
  logic unused_idle;
  assign unused_idle = ap_idle;

  assign in_flight = (state_q == StStart) || (state_q == StWaitDone);
  assign capture   = in_flight && ap_done;
  assign expire    = in_flight && (timer_q == TimerLast);

  always_comb begin
    state_d       = state_q;
    bb_cmd_d      = bb_cmd_q;
    bb_x_d        = bb_x_q;
    bb_y_d        = bb_y_q;
    timer_d       = timer_q;
    rsp_sum_d     = rsp_sum_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    txn_d         = txn_q;
    err_d         = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          bb_cmd_d = req_cmd;
          bb_x_d   = req_x;
          bb_y_d   = req_y;
          timer_d  = '0;
          state_d  = StStart;
        end
      end
      StStart, StWaitDone: begin
        timer_d = timer_q + 16'd1;
        // A done on the expiry edge wins over the watchdog.
        if (capture) begin
          rsp_sum_d     = bb_res[4:0];
          rsp_err_d     = bb_res[5];
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (expire) begin
          rsp_sum_d     = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end else if ((state_q == StStart) && ap_ready) begin
          state_d = StWaitDone;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          if (txn_q != CntMax) txn_d = txn_q + 1'b1;
          if (rsp_err_q && (err_q != CntMax)) err_d = err_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q       <= StIdle;
      bb_cmd_q      <= 1'b0;
      bb_x_q        <= '0;
      bb_y_q        <= 1'b0;
      timer_q       <= '0;
      rsp_sum_q     <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      txn_q         <= '0;
      err_q         <= '0;
      ce_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      bb_cmd_q      <= bb_cmd_d;
      bb_x_q        <= bb_x_d;
      bb_y_q        <= bb_y_d;
      timer_q       <= timer_d;
      rsp_sum_q     <= rsp_sum_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      txn_q         <= txn_d;
      err_q         <= err_d;
      ce_q          <= 1'b1;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign ap_start    = (state_q == StStart);
  assign ap_continue = capture;
  assign ap_ce       = ce_q;
  assign bb_cmd      = bb_cmd_q;
  assign bb_x        = bb_x_q;
  assign bb_y        = bb_y_q;
  assign rsp_valid   = (state_q == StResp);
  assign rsp_sum     = rsp_sum_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != StIdle);
  assign txn_count   = txn_q;
  assign err_count   = err_q;

endmodule
